// File: rtl/sdram_video_reader.sv
// Raster reader for one read-side FIFO port of the 4-port SDRAM controller.
// Generates VGA-style timing, pops one FIFO word per active pixel, reloads
// the port once per frame in vertical blank and waits for a prefill level.
module sdram_video_reader #(
  parameter int DSIZE    = 16,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PREFILL  = 256,
  parameter int LOAD_CYC = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [DSIZE-1:0] RD_DATA,
  input  logic             RD_EMPTY,
  input  logic [15:0]      RD_USE,
  output logic             RD,
  output logic             RD_LOAD,
  output logic [DSIZE-1:0] PIX_DATA,
  output logic             DE,
  output logic             HS,
  output logic             VS,
  output logic             FRAME_START,
  output logic             UNDERFLOW
);

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam int          LW     = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYC - 1);
  localparam logic [15:0] PREFILL_LVL = 16'(PREFILL);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PREFILL, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [10:0]   h, v, h_nxt, v_nxt;
  logic [LW-1:0] load_cnt;
  logic          act, in_run, underrun, de_raw, hs_raw, vs_raw, rd_q;

  // Next raster position and next state. Frame-boundary decisions are keyed
  // on the upcoming position so the new state is already in force on the
  // first pixel of the frame (or the first blank line).
  always_comb begin
    h_nxt     = h;
    v_nxt     = v;
    state_nxt = state;
    if (!EN || state == S_IDLE) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (h == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v == V_LAST) ? '0 : v + 11'd1;
    end else begin
      h_nxt = h + 11'd1;
    end
    case (state)
      S_IDLE:    state_nxt = S_LOAD;
      S_LOAD:    if (load_cnt == LOAD_LAST) state_nxt = S_PREFILL;
      S_PREFILL: if (h_nxt == '0 && v_nxt == '0 && RD_USE >= PREFILL_LVL) state_nxt = S_RUN;
      S_RUN:     if (h_nxt == '0 && v_nxt == V_ACT) state_nxt = S_LOAD;
      default:   state_nxt = S_IDLE;
    endcase
    if (!EN) state_nxt = S_IDLE;
  end

  // State register, raster counters and reload pulse length counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      h        <= '0;
      v        <= '0;
      load_cnt <= '0;
    end else begin
      state    <= state_nxt;
      h        <= h_nxt;
      v        <= v_nxt;
      load_cnt <= (state == S_LOAD) ? load_cnt + LW'(1) : '0;
    end
  end

  // Raw (cycle 0) timing, FIFO requests and black-pixel gating.
  always_comb begin
    act      = (h < H_ACT) && (v < V_ACT);
    in_run   = (state == S_RUN);
    RD       = act && in_run && !RD_EMPTY;
    RD_LOAD  = (state == S_LOAD);
    underrun = act && in_run && RD_EMPTY;
    de_raw   = act && (state != S_IDLE);
    hs_raw   = (state == S_IDLE) || !(h >= H_SS && h < H_SE);
    vs_raw   = (state == S_IDLE) || !(v >= V_SS && v < V_SE);
    PIX_DATA = rd_q ? RD_DATA : '0;
  end

  // Output stage: raw timing delayed one clock to line up with FIFO data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      DE          <= 1'b0;
      HS          <= 1'b1;
      VS          <= 1'b1;
      FRAME_START <= 1'b0;
      UNDERFLOW   <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      DE          <= de_raw;
      HS          <= hs_raw;
      VS          <= vs_raw;
      FRAME_START <= act && in_run && h == '0 && v == '0;
      UNDERFLOW   <= EN && (UNDERFLOW || underrun);
      rd_q        <= RD;
    end
  end

endmodule

// File: tb/tb_sdram_video_reader.sv
// Self-checking bench for sdram_video_reader using a reduced raster
// (16 x 9 clocks per frame) and a behavioural non-show-ahead FIFO.
module tb_sdram_video_reader;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam int PF = 8;
  localparam int LC = 4;
  localparam int C_DROP = 4 * FT + HT + 4;

  logic        clk = 1'b0;
  logic        rst, en, rd_empty, rd, rd_load, de, hs, vs, fs, uf;
  logic [15:0] rd_data, rd_use, pix;

  sdram_video_reader #(
    .DSIZE(16), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .PREFILL(PF), .LOAD_CYC(LC)
  ) dut (
    .CLK(clk), .RESET(rst), .EN(en), .RD_DATA(rd_data), .RD_EMPTY(rd_empty),
    .RD_USE(rd_use), .RD(rd), .RD_LOAD(rd_load), .PIX_DATA(pix), .DE(de),
    .HS(hs), .VS(vs), .FRAME_START(fs), .UNDERFLOW(uf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   c;
    logic de, hs, vs, ld, fs;
  } vec_t;

  int          tests = 0, fails = 0;
  logic [15:0] q[$];
  logic [15:0] sb[$];
  int          wnext = 1, cap = 32, skipped = 0;
  logic        fe = 1'b0, uf_exp = 1'b0, rd_prev = 1'b0, ld_prev = 1'b0;
  logic        run[0:5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, got, exp, $time);
    end
  endtask

  // FIFO model: act on the request seen at the last edge, refill, then settle.
  task automatic settle();
    rd_data = 16'hA5A5;
    if (ld_prev) begin
      q.delete();
      wnext = 1;
    end else if (rd_prev) begin
      chk("fifo_nonempty_on_rd", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) rd_data = q.pop_front();
    end
    if (q.size() < cap) begin
      q.push_back(16'(wnext));
      wnext++;
    end
    rd_empty = fe || (q.size() == 0);
    rd_use   = 16'(q.size());
    #1;
    rd_prev = rd;
    ld_prev = rd_load;
  endtask

  // Expected behaviour for cycle c after enable, from raster arithmetic.
  task automatic check_cycle(input int c);
    int p, pm, pf, ph, pv, m, fr, hh, vv;
    logic ede, ehs, evs, efs, act_now, running, erd, under, eld;
    logic [15:0] epix, sb_pix;
    ede = 1'b0; ehs = 1'b1; evs = 1'b1; efs = 1'b0;
    if (c > 0) begin
      p = c - 1; pm = p % FT; pf = p / FT; ph = pm % HT; pv = pm / HT;
      ede = (ph < HA) && (pv < VA);
      ehs = !(ph >= HA + HF && ph < HA + HF + HSW);
      evs = !(pv >= VA + VF && pv < VA + VF + VSW);
      efs = (pm == 0) && run[pf];
    end
    m = c % FT; fr = c / FT; hh = m % HT; vv = m / HT;
    if (m == 0) skipped = 0;
    act_now = (hh < HA) && (vv < VA);
    running = run[fr];
    erd     = running && act_now && !fe;
    under   = running && act_now && fe;
    eld     = (c < LC) || (running && m >= VA * HT && m < VA * HT + LC);
    sb_pix  = (sb.size() > 0) ? sb.pop_front() : 16'hFFFF;
    chk("de", 32'(de), 32'(ede));
    chk("hs", 32'(hs), 32'(ehs));
    chk("vs", 32'(vs), 32'(evs));
    chk("frame_start", 32'(fs), 32'(efs));
    chk("rd", 32'(rd), 32'(erd));
    chk("rd_load", 32'(rd_load), 32'(eld));
    chk("pix_data", 32'(pix), 32'(sb_pix));
    chk("underflow", 32'(uf), 32'(uf_exp));
    epix = erd ? 16'(1 + vv * HA + hh - skipped) : 16'h0000;
    sb.push_back(epix);
    if (under) begin
      skipped++;
      uf_exp = 1'b1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd"}, 32'(rd), 32'd0);
    chk({tag, "_rd_load"}, 32'(rd_load), 32'd0);
    chk({tag, "_pix"}, 32'(pix), 32'd0);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_hs"}, 32'(hs), 32'd1);
    chk({tag, "_vs"}, 32'(vs), 32'd1);
    chk({tag, "_fs"}, 32'(fs), 32'd0);
    chk({tag, "_uf"}, 32'(uf), 32'd0);
  endtask

  initial begin
    vec_t tbl[22];
    int   ti, rd_cnt;
    tbl[0]  = '{0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{3,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{4,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{8,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{9,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{10,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{11,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{13,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{14,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{17,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{65,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{80,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{81,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{112, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{113, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{145, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{208, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{212, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{289, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{352, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{433, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    run[0] = 1'b0; run[1] = 1'b1; run[2] = 1'b0;
    run[3] = 1'b1; run[4] = 1'b1; run[5] = 1'b0;
    rd_data = 16'hA5A5; rd_empty = 1'b1; rd_use = '0;

    // T1: reset held with EN=1
    rst = 1'b1; en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); settle();
    chk_reset_vals("reset");
    rst = 1'b0; en = 1'b0;
    @(negedge clk); settle();
    chk("idle_de", 32'(de), 32'd0);
    chk("idle_rd_load", 32'(rd_load), 32'd0);
    en = 1'b1;
    sb.delete(); sb.push_back(16'h0000);

    // T2-T5 and T6 drop: continuous raster from enable
    ti = 0; rd_cnt = 0;
    for (int c = 0; c <= C_DROP; c++) begin
      @(negedge clk);
      fe = (c >= 4 * FT / 4 * 3 + HT + 2 && c <= 3 * FT + HT + 6);
      if (c == 200) cap = 5;
      if (c == 300) cap = 32;
      if (c == C_DROP) en = 1'b0;
      settle();
      check_cycle(c);
      if (c >= FT && c < 2 * FT && rd) rd_cnt++;
      if (ti < 22 && tbl[ti].c == c) begin
        chk("tbl_de", 32'(de), 32'(tbl[ti].de));
        chk("tbl_hs", 32'(hs), 32'(tbl[ti].hs));
        chk("tbl_vs", 32'(vs), 32'(tbl[ti].vs));
        chk("tbl_rd_load", 32'(rd_load), 32'(tbl[ti].ld));
        chk("tbl_frame_start", 32'(fs), 32'(tbl[ti].fs));
        ti++;
      end
    end
    chk("tbl_all_applied", 32'(ti), 32'd22);
    chk("rd_per_frame", 32'(rd_cnt), 32'(HA * VA));

    // T6: after EN drop
    @(negedge clk); settle();
    chk("drop1_rd", 32'(rd), 32'd0);
    chk("drop1_de", 32'(de), 32'd1);
    chk("drop1_pix", 32'(pix), 32'(sb.pop_front()));
    chk("drop1_uf", 32'(uf), 32'd0);
    @(negedge clk); settle();
    chk_reset_vals("drop2");
    repeat (3) begin
      @(negedge clk); settle();
    end
    chk("idle_hold_de", 32'(de), 32'd0);

    // Re-enable restarts at H=V=0 with reload, then reset mid-frame
    for (int i = 0; i < 6; i++) run[i] = 1'b0;
    sb.delete(); sb.push_back(16'h0000);
    skipped = 0; uf_exp = 1'b0; fe = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      settle();
      check_cycle(c);
    end
    @(negedge clk); rst = 1'b1;
    settle();
    check_cycle(19);
    @(negedge clk); settle();
    chk_reset_vals("midreset");
    rst = 1'b0;
    @(negedge clk); settle();
    chk("rearm_rd_load", 32'(rd_load), 32'd1);
    chk("rearm_de", 32'(de), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
